// File: rtl/rf_pkg.sv
// Shared definitions for the register-file write-back path.
package rf_pkg;

  localparam int NUM_REGS   = 21;
  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  // One pending register write: destination and value.
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

endpackage

// File: rtl/rf_ldq.sv
// Load response buffer: small synchronous FIFO of write-back entries.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module rf_ldq
  import rf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t push_entry,
  input  logic      pop,
  output wb_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] PTR_INC = (PTR_W + 1)'(1);

  wb_entry_t      mem [DEPTH];
  logic [PTR_W:0] wr_ptr;
  logic [PTR_W:0] rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign head  = mem[rd_ptr[PTR_W-1:0]];

  // Advance read/write pointers; a push while full is refused.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_INC;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_INC;
    end
  end

  // Entry storage; contents are don't-care until the write pointer passes them.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[PTR_W-1:0]] <= push_entry;
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Register-file write-port controller. Merges ALU results and buffered load
// responses into one registered write (WE3/A3/WD3), tracks outstanding loads
// in a scoreboard for decode stalls, and bounds how long the ALU can starve
// a waiting load.
module rf_writeback_ctrl #(
  parameter int NUM_REGS   = rf_pkg::NUM_REGS,
  parameter int LDQ_DEPTH  = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic                          CLK,
  input  logic                          reset,
  input  logic                          issue_valid,
  input  logic [rf_pkg::REG_ADDR_W-1:0] issue_rd,
  input  logic [rf_pkg::REG_ADDR_W-1:0] A1,
  input  logic [rf_pkg::REG_ADDR_W-1:0] A2,
  output logic                          stall,
  input  logic                          alu_valid,
  output logic                          alu_ready,
  input  logic [rf_pkg::REG_ADDR_W-1:0] alu_rd,
  input  logic [rf_pkg::XLEN-1:0]       alu_data,
  input  logic                          ld_valid,
  output logic                          ld_ready,
  input  logic [rf_pkg::REG_ADDR_W-1:0] ld_rd,
  input  logic [rf_pkg::XLEN-1:0]       ld_data,
  output logic                          WE3,
  output logic [rf_pkg::REG_ADDR_W-1:0] A3,
  output logic [rf_pkg::XLEN-1:0]       WD3,
  output logic                          err
);

  import rf_pkg::*;

  localparam int                     STARVE_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0]    STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [STARVE_W-1:0]    STARVE_INC = STARVE_W'(1);
  localparam logic [REG_ADDR_W:0]    REG_LIM    = (REG_ADDR_W + 1)'(NUM_REGS);

  // Destination is an implemented architectural register.
  function automatic logic rd_legal(input logic [REG_ADDR_W-1:0] rd);
    return {1'b0, rd} < REG_LIM;
  endfunction

  wb_entry_t              ld_entry;
  wb_entry_t              ldq_head;
  logic                   ldq_push;
  logic                   ldq_pop;
  logic                   ldq_full;
  logic                   ldq_empty;
  logic                   alu_take;
  logic                   sel_vld_p0;
  logic [REG_ADDR_W-1:0]  sel_rd_p0;
  logic [XLEN-1:0]        sel_data_p0;
  logic                   wr_en_p0;
  logic [NUM_REGS-1:0]    busy;
  logic [NUM_REGS-1:0]    busy_n;
  logic [STARVE_W-1:0]    starve;
  logic [STARVE_W-1:0]    starve_n;
  logic                   err_n;

  assign ld_entry  = '{rd: ld_rd, data: ld_data};
  assign ld_ready  = !ldq_full;
  assign ldq_push  = ld_valid && !ldq_full;
  // Once the load head has lost STARVE_MAX times in a row, the ALU must wait.
  assign alu_ready = (starve < STARVE_LIM) || ldq_empty;
  assign alu_take  = alu_valid && alu_ready;
  assign ldq_pop   = !alu_take && !ldq_empty;

  rf_ldq #(
    .DEPTH      (LDQ_DEPTH)
  ) u_ldq (
    .clk        (CLK),
    .rst        (reset),
    .push       (ldq_push),
    .push_entry (ld_entry),
    .pop        (ldq_pop),
    .head       (ldq_head),
    .full       (ldq_full),
    .empty      (ldq_empty)
  );

  // Pick this cycle's write source; x0 and illegal destinations are consumed
  // but never reach the write port.
  always_comb begin
    sel_vld_p0  = 1'b0;
    sel_rd_p0   = ldq_head.rd;
    sel_data_p0 = ldq_head.data;
    if (alu_take) begin
      sel_vld_p0  = 1'b1;
      sel_rd_p0   = alu_rd;
      sel_data_p0 = alu_data;
    end else if (!ldq_empty) begin
      sel_vld_p0  = 1'b1;
    end
    wr_en_p0 = sel_vld_p0 && (sel_rd_p0 != '0) && rd_legal(sel_rd_p0);
  end

  // Decode stall: either source names a register with a load still in flight.
  always_comb begin
    stall = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (busy[i] && ((A1 == REG_ADDR_W'(i)) || (A2 == REG_ADDR_W'(i)))) stall = 1'b1;
    end
  end

  // Next scoreboard, starve count and error flag; a new issue to the same rd
  // overrides the clear from the older load being written back.
  always_comb begin
    busy_n = busy;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ldq_pop && (ldq_head.rd == REG_ADDR_W'(i))) busy_n[i] = 1'b0;
      if (issue_valid && (issue_rd == REG_ADDR_W'(i))) busy_n[i] = 1'b1;
    end
    busy_n[0] = 1'b0;

    starve_n = starve;
    if (ldq_empty || ldq_pop) starve_n = '0;
    else if (alu_take)        starve_n = starve + STARVE_INC;

    err_n = err ||
            (issue_valid && !rd_legal(issue_rd)) ||
            (sel_vld_p0 && !rd_legal(sel_rd_p0));
  end

  // State and registered write port; A3/WD3 keep their last value when idle.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      busy   <= '0;
      starve <= '0;
      err    <= 1'b0;
      WE3    <= 1'b0;
      A3     <= '0;
      WD3    <= '0;
    end else begin
      busy   <= busy_n;
      starve <= starve_n;
      err    <= err_n;
      WE3    <= wr_en_p0;
      if (wr_en_p0) begin
        A3  <= sel_rd_p0;
        WD3 <= sel_data_p0;
      end
    end
  end

endmodule
